// File: rtl/sbus_spi_responder.sv
// System-bus responder exposing a byte-wide mode-0 SPI master as four registers
// (CTRL, TXDR, RXDR, STATUS) decoded under a 4-bit block base address.
module sbus_spi_responder #(
    parameter logic [3:0] BASE   = 4'h0,
    parameter int         CLKDIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sbus_stb,
    input  logic       sbus_rw,
    input  logic [7:0] sbus_addr,
    input  logic [7:0] sbus_wdata,
    output logic [7:0] sbus_rdata,
    output logic       sbus_ack,
    input  logic       spi_miso,
    output logic       spi_mosi,
    output logic       spi_sclk,
    output logic       spi_cs_n,
    output logic       irq
);

    localparam logic [3:0] REG_CTRL   = 4'h0;
    localparam logic [3:0] REG_TXDR   = 4'h1;
    localparam logic [3:0] REG_RXDR   = 4'h2;
    localparam logic [3:0] REG_STATUS = 4'h3;
    localparam logic [7:0] DIV_LOAD   = 8'(CLKDIV - 1);

    typedef enum logic [1:0] {
        B_IDLE     = 2'd0,
        B_ACK      = 2'd1,
        B_WAIT_LOW = 2'd2
    } bus_state_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2
    } spi_state_t;

    bus_state_t bus_state_reg, bus_state_next;
    spi_state_t spi_state_reg, spi_state_next;

    logic       ctrl_cs_reg;
    logic [7:0] rxdr_reg;
    logic       rrdy_reg;
    logic       ovr_reg;
    logic [7:0] shifter_reg;
    logic [7:0] div_cnt_reg;
    logic [2:0] bit_cnt_reg;
    logic       sclk_reg;
    logic       mosi_reg;

    logic       busy;
    logic       wr_commit;
    logic       rd_access;
    logic       ctrl_write;
    logic       tx_write;
    logic       tx_load;
    logic       tx_drop;
    logic       status_write;
    logic       rx_read;
    logic       phase_end;
    logic       sclk_rise;
    logic       sclk_fall;
    logic       last_bit;
    logic       xfer_done;
    logic       ovr_set;
    logic [7:0] read_mux;

    // ---------------- bus FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_state_reg <= B_IDLE;
        end else begin
            bus_state_reg <= bus_state_next;
        end
    end

    always_comb begin
        bus_state_next = bus_state_reg;
        case (bus_state_reg)
            B_IDLE: begin
                if (sbus_stb && (sbus_addr[7:4] == BASE)) begin
                    bus_state_next = B_ACK;
                end
            end
            B_ACK: begin
                bus_state_next = B_WAIT_LOW;
            end
            B_WAIT_LOW: begin
                if (!sbus_stb) begin
                    bus_state_next = B_IDLE;
                end
            end
            default: begin
                bus_state_next = B_IDLE;
            end
        endcase
    end

    // The initiator holds addr/rw/wdata stable until ack, so they are decoded live.
    always_comb begin
        sbus_ack     = (bus_state_reg == B_ACK);
        wr_commit    = sbus_ack && sbus_rw;
        rd_access    = sbus_ack && !sbus_rw;
        ctrl_write   = wr_commit && (sbus_addr[3:0] == REG_CTRL);
        tx_write     = wr_commit && (sbus_addr[3:0] == REG_TXDR);
        status_write = wr_commit && (sbus_addr[3:0] == REG_STATUS);
        rx_read      = rd_access && (sbus_addr[3:0] == REG_RXDR);
        tx_load      = tx_write && !busy;
        tx_drop      = tx_write && busy;
        case (sbus_addr[3:0])
            REG_CTRL:   read_mux = {7'b0, ctrl_cs_reg};
            REG_RXDR:   read_mux = rxdr_reg;
            REG_STATUS: read_mux = {5'b0, ovr_reg, rrdy_reg, busy};
            default:    read_mux = 8'h00;
        endcase
        sbus_rdata = rd_access ? read_mux : 8'h00;
    end

    // ---------------- SPI FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_state_reg <= S_IDLE;
        end else begin
            spi_state_reg <= spi_state_next;
        end
    end

    always_comb begin
        spi_state_next = spi_state_reg;
        case (spi_state_reg)
            S_IDLE: begin
                if (tx_load) begin
                    spi_state_next = S_LOW;
                end
            end
            S_LOW: begin
                if (phase_end) begin
                    spi_state_next = S_HIGH;
                end
            end
            S_HIGH: begin
                if (phase_end) begin
                    spi_state_next = last_bit ? S_IDLE : S_LOW;
                end
            end
            default: begin
                spi_state_next = S_IDLE;
            end
        endcase
    end

    // Completion coincides with the falling edge that ends the eighth high phase.
    always_comb begin
        busy      = (spi_state_reg != S_IDLE);
        phase_end = busy && (div_cnt_reg == 8'd0);
        sclk_rise = phase_end && (spi_state_reg == S_LOW);
        sclk_fall = phase_end && (spi_state_reg == S_HIGH);
        last_bit  = (bit_cnt_reg == 3'd7);
        xfer_done = sclk_fall && last_bit;
        ovr_set   = tx_drop || (xfer_done && rrdy_reg && !rx_read);
    end

    // ---------------- SPI datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_reg <= 8'd0;
            bit_cnt_reg <= 3'd0;
            shifter_reg <= 8'd0;
            sclk_reg    <= 1'b0;
            mosi_reg    <= 1'b0;
        end else begin
            if (tx_load || phase_end) begin
                div_cnt_reg <= DIV_LOAD;
            end else if (busy) begin
                div_cnt_reg <= div_cnt_reg - 8'd1;
            end

            if (tx_load) begin
                bit_cnt_reg <= 3'd0;
            end else if (sclk_fall && !last_bit) begin
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end

            if (tx_load) begin
                shifter_reg <= sbus_wdata;
                mosi_reg    <= sbus_wdata[7];
                sclk_reg    <= 1'b0;
            end else if (sclk_rise) begin
                shifter_reg <= {shifter_reg[6:0], spi_miso};
                sclk_reg    <= 1'b1;
            end else if (sclk_fall) begin
                sclk_reg <= 1'b0;
                if (!last_bit) begin
                    mosi_reg <= shifter_reg[7];
                end
            end
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_cs_reg <= 1'b0;
            rxdr_reg    <= 8'h00;
            rrdy_reg    <= 1'b0;
            ovr_reg     <= 1'b0;
        end else begin
            if (ctrl_write) begin
                ctrl_cs_reg <= sbus_wdata[0];
            end

            if (xfer_done) begin
                rxdr_reg <= shifter_reg;
                rrdy_reg <= 1'b1;
            end else if (rx_read) begin
                rrdy_reg <= 1'b0;
            end

            // A fresh overrun outranks a simultaneous software clear.
            if (ovr_set) begin
                ovr_reg <= 1'b1;
            end else if (status_write && sbus_wdata[2]) begin
                ovr_reg <= 1'b0;
            end
        end
    end

    assign spi_sclk = sclk_reg;
    assign spi_mosi = mosi_reg;
    assign spi_cs_n = ~ctrl_cs_reg;
    assign irq      = rrdy_reg;

endmodule
